// File: rtl/wb_forward_unit.sv
// Write-back end of the register-file interface: X (memory) and Y (write-back) slots,
// operand forwarding, load-use / slow-memory stall. Optional macro WB_RETIRE_CNT_EN adds retire_count.
module wb_forward_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu,
    input  logic              in_regwrite,
    input  logic              in_load,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] s1_idx,
    input  logic [REG_AW-1:0] s2_idx,
    input  logic              s1_used,
    input  logic              s2_used,
    output logic [REG_AW-1:0] D_dest,
    output logic [DATA_W-1:0] data,
    output logic              RegWrite_to_Reg,
    output logic [DATA_W-1:0] X_reg,
    output logic [DATA_W-1:0] Y_reg,
    output logic [1:0]        s1_src,
    output logic [1:0]        s2_src,
    output logic              stall
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_count
`endif
);

    logic              r_x_valid;
    logic [REG_AW-1:0] r_x_dest;
    logic [DATA_W-1:0] r_x_alu;
    logic              r_x_regwrite;
    logic              r_x_load;

    logic              r_y_valid;
    logic [REG_AW-1:0] r_y_dest;
    logic [DATA_W-1:0] r_y_data;
    logic              r_y_regwrite;

    logic              w_xw;
    logic              w_yw;
    logic              w_mem_wait;
    logic              w_load_use;

    logic [REG_AW-1:0] w_s_idx  [2];
    logic              w_s_used [2];
    logic [1:0]        w_s_src  [2];
    logic [1:0]        w_x_hit;

    assign w_xw       = r_x_valid & r_x_regwrite;
    assign w_yw       = r_y_valid & r_y_regwrite;
    assign w_mem_wait = r_x_valid & r_x_load & ~mem_valid;

    assign w_s_idx[0]  = s1_idx;
    assign w_s_idx[1]  = s2_idx;
    assign w_s_used[0] = s1_used;
    assign w_s_used[1] = s2_used;

    // X wins over Y because it holds the younger result for the same register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign w_x_hit[gi] = w_s_used[gi] & w_xw & (w_s_idx[gi] == r_x_dest);
            always_comb begin
                w_s_src[gi] = 2'b00;
                if (w_x_hit[gi] && !r_x_load) begin
                    w_s_src[gi] = 2'b01;
                end else if (w_s_used[gi] && w_yw && (w_s_idx[gi] == r_y_dest)) begin
                    w_s_src[gi] = 2'b10;
                end
            end
        end
    endgenerate

    assign w_load_use = r_x_load & (|w_x_hit);

    assign stall           = w_mem_wait | w_load_use;
    assign s1_src          = w_s_src[0];
    assign s2_src          = w_s_src[1];
    assign RegWrite_to_Reg = w_yw & ~reset;
    assign D_dest          = r_y_dest;
    assign data            = r_y_data;
    assign X_reg           = r_x_alu;
    assign Y_reg           = r_y_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_valid    <= 1'b0;
            r_x_dest     <= '0;
            r_x_alu      <= '0;
            r_x_regwrite <= 1'b0;
            r_x_load     <= 1'b0;
            r_y_valid    <= 1'b0;
            r_y_dest     <= '0;
            r_y_data     <= '0;
            r_y_regwrite <= 1'b0;
        end else if (w_mem_wait) begin
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid    <= r_x_valid;
            r_y_dest     <= r_x_dest;
            r_y_data     <= r_x_load ? mem_data : r_x_alu;
            r_y_regwrite <= r_x_regwrite;
            if (w_load_use) begin
                r_x_valid <= 1'b0;
            end else begin
                r_x_valid    <= in_valid;
                r_x_dest     <= in_dest;
                r_x_alu      <= in_alu;
                r_x_regwrite <= in_regwrite;
                r_x_load     <= in_load;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (r_y_valid) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule
